// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam int ENTRY_W = XLEN + ILEN;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_e;

  // Sequential fetch advances one word; wraps modulo 2^32.
  function automatic logic [XLEN-1:0] next_word_pc(input logic [XLEN-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small FIFO holding {pc, instr} pairs between fetch and decode.
// Pop and push may occur together when full; flush empties the buffer
// regardless of a simultaneous pop (the head is still considered consumed).
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int PTRW  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int CNTW  = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push_i,
  input  logic               pop_i,
  input  logic               flush_i,
  input  logic [ENTRY_W-1:0] data_i,
  output logic [ENTRY_W-1:0] data_o,
  output logic [CNTW-1:0]    count_o
);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [PTRW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTRW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CNTW-1:0]    count_q, count_d;

  // Pointer/count bookkeeping; flush returns to an empty, realigned buffer.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) begin
        wr_ptr_d = (wr_ptr_q == PTRW'(DEPTH - 1)) ? '0 : wr_ptr_q + PTRW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_i) begin
        rd_ptr_d = (rd_ptr_q == PTRW'(DEPTH - 1)) ? '0 : rd_ptr_q + PTRW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + CNTW'(1);
        2'b01:   count_d = count_q - CNTW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Storage and pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i && !flush_i) begin
        mem_q[wr_ptr_q] <= data_i;
      end
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign data_o  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: sequential PC generation, redirect/halt control,
// and a small decoupling buffer toward decode.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              ADDWIDTH = 12,
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int              DEPTH    = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic [ADDWIDTH-1:0] imem_addr,
  input  logic [ILEN-1:0]     imem_data,
  input  logic                redirect_valid,
  input  logic [XLEN-1:0]     redirect_pc,
  input  logic                halt_req,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ILEN-1:0]     out_instr,
  output logic [XLEN-1:0]     out_pc,
  output logic                misalign_err,
  output logic                halted
);

  localparam int CNTW = $clog2(DEPTH + 1);

  fetch_state_e        state_q, state_d;
  logic [XLEN-1:0]     pc_q, pc_d;
  logic                misalign_q, misalign_d;

  logic [CNTW-1:0]     count_s;
  logic [ENTRY_W-1:0]  head_s;
  logic                transfer_s;
  logic                flush_s;
  logic                push_s;
  logic                has_room_s;

  assign transfer_s = out_valid && out_ready;
  assign flush_s    = redirect_valid && (state_q != ST_IDLE);
  assign has_room_s = (count_s < CNTW'(DEPTH)) || transfer_s;
  assign push_s     = (state_q == ST_FETCH) && !halt_req && !redirect_valid && has_room_s;

  // Next state, PC and misalignment flag.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    misalign_d = 1'b0;
    if (flush_s) begin
      // Redirect wins over halt and keeps the current non-IDLE state.
      pc_d       = {redirect_pc[XLEN-1:2], 2'b00};
      misalign_d = |redirect_pc[1:0];
      state_d    = state_q;
    end else begin
      case (state_q)
        ST_IDLE:   state_d = ST_FETCH;
        ST_FETCH:  state_d = halt_req ? ST_HALTED : ST_FETCH;
        ST_HALTED: state_d = halt_req ? ST_HALTED : ST_FETCH;
        default:   state_d = ST_IDLE;
      endcase
      if (push_s) begin
        pc_d = next_word_pc(pc_q);
      end else begin
        pc_d = pc_q;
      end
    end
  end

  // Control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_s),
    .pop_i   (transfer_s),
    .flush_i (flush_s),
    .data_i  ({pc_q, imem_data}),
    .data_o  (head_s),
    .count_o (count_s)
  );

  assign imem_addr    = pc_q[ADDWIDTH+1:2];
  assign out_valid    = (count_s != '0);
  assign out_pc       = head_s[ENTRY_W-1:ILEN];
  assign out_instr    = head_s[ILEN-1:0];
  assign misalign_err = misalign_q;
  assign halted       = (state_q == ST_HALTED);

endmodule
